// File: rtl/flood_fill_ctrl.sv
// flood_fill_ctrl
//   Turns player open/flag commands into strobes for the board cover array.
//   When a zero-count cell opens, its in-bounds neighbours are pushed onto an
//   internal LIFO and opened in turn (flood fill). The block also tracks mine
//   hits and how many cells have been opened since reset.
//
// Build option: define FLOOD_FILL_EN to build the neighbour LIFO and the
//   EXPAND/POP path. Without it only the commanded cell is opened, and
//   overflow_o is tied low.
//
// Ports
//   clk_i, reset_n_i       clock (rising edge), asynchronous active-low reset
//   usr_valid_i/ready_o    player command handshake
//   usr_flag_i/open_i      command kind; both or neither set is discarded
//   usr_x_i/usr_y_i        command coordinate
//   cov_flag_o/open_o      one-cycle strobes to the cover array
//   cov_x_o/cov_y_o        cover array address
//   cov_opened_i           cover array: cell became opened (one cycle after cov_open_o)
//   adj_count_i, is_mine_i combinational cell info at cov_x_o/cov_y_o
//   busy_o                 controller not in IDLE
//   mine_hit_o, overflow_o sticky status flags
//   cells_opened_o         opened-cell count
//
// state    | meaning
// S_INIT   | cover array self-clear, X_SIZE*Y_SIZE cycles
// S_IDLE   | accepting player commands
// S_ISSUE  | cov_open strobe at cur
// S_WAIT   | evaluating the cover array response for cur
// S_EXPAND | push in-range neighbours of a zero cell, one per cycle
// S_POP    | fetch the next pending cell from the LIFO

module flood_fill_ctrl #(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_COORD_BITS = 4,
    parameter int Y_COORD_BITS = 4,
    parameter int STACK_DEPTH  = 256,
    parameter int STACK_BITS   = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 usr_valid_i,
    output logic                                 usr_ready_o,
    input  logic                                 usr_flag_i,
    input  logic                                 usr_open_i,
    input  logic [X_COORD_BITS-1:0]              usr_x_i,
    input  logic [Y_COORD_BITS-1:0]              usr_y_i,
    output logic                                 cov_flag_o,
    output logic                                 cov_open_o,
    output logic [X_COORD_BITS-1:0]              cov_x_o,
    output logic [Y_COORD_BITS-1:0]              cov_y_o,
    input  logic                                 cov_opened_i,
    input  logic [3:0]                           adj_count_i,
    input  logic                                 is_mine_i,
    output logic                                 busy_o,
    output logic                                 mine_hit_o,
    output logic                                 overflow_o,
    output logic [X_COORD_BITS+Y_COORD_BITS:0]   cells_opened_o
);

    localparam int IW = X_COORD_BITS + Y_COORD_BITS;
    localparam int CW = IW + 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(X_SIZE * Y_SIZE - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_EXPAND, S_POP} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           init_cnt_q, init_cnt_d;
    logic [X_COORD_BITS-1:0] cur_x_q, cur_x_d, cov_x_q, cov_x_d;
    logic [Y_COORD_BITS-1:0] cur_y_q, cur_y_d, cov_y_q, cov_y_d;
    logic                    cov_flag_q, cov_flag_d, cov_open_q, cov_open_d;
    logic                    usr_ready_q, usr_ready_d, busy_q, busy_d;
    logic                    mine_hit_q, mine_hit_d;
    logic [CW-1:0]           cells_q, cells_d;

`ifdef FLOOD_FILL_EN
    localparam logic [STACK_BITS:0] SP_ONE  = (STACK_BITS+1)'(1);
    localparam logic [STACK_BITS:0] SP_FULL = (STACK_BITS+1)'(STACK_DEPTH);

    logic [STACK_BITS:0]     sp_q, sp_d;
    logic [2:0]              nbr_q, nbr_d;
    logic                    overflow_q, overflow_d;
    logic [IW-1:0]           stack_q [STACK_DEPTH];
    logic                    push, nbr_valid;
    logic [IW-1:0]           push_data, top_data;
    int                      dx, dy, nx, ny;

    // Neighbour offset for the current nbr index; range check is done in
    // signed integer space so edge cells never wrap to the far side.
    always_comb begin
        dx = 0;
        dy = 0;
        case (nbr_q)
            3'd0: begin dx = -1; dy = -1; end
            3'd1: begin dx =  0; dy = -1; end
            3'd2: begin dx =  1; dy = -1; end
            3'd3: begin dx = -1; dy =  0; end
            3'd4: begin dx =  1; dy =  0; end
            3'd5: begin dx = -1; dy =  1; end
            3'd6: begin dx =  0; dy =  1; end
            default: begin dx = 1; dy = 1; end
        endcase
        nx        = int'(cur_x_q) + dx;
        ny        = int'(cur_y_q) + dy;
        nbr_valid = (nx >= 0) && (nx < X_SIZE) && (ny >= 0) && (ny < Y_SIZE);
        push_data = {X_COORD_BITS'(nx), Y_COORD_BITS'(ny)};
    end

    // With a full stack the low index bits wrap to zero, so minus one still
    // addresses the top entry.
    assign top_data = stack_q[sp_q[STACK_BITS-1:0] - STACK_BITS'(1)];

    always_ff @(posedge clk_i) begin
        if (push) stack_q[sp_q[STACK_BITS-1:0]] <= push_data;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sp_q       <= '0;
            nbr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            sp_q       <= sp_d;
            nbr_q      <= nbr_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;
`else
    logic unused_adj;
    assign unused_adj = ^adj_count_i;
    assign overflow_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cov_x_d    = cov_x_q;
        cov_y_d    = cov_y_q;
        cov_flag_d = 1'b0;
        cov_open_d = 1'b0;
        mine_hit_d = mine_hit_q;
        cells_d    = cells_q;
`ifdef FLOOD_FILL_EN
        sp_d       = sp_q;
        nbr_d      = nbr_q;
        overflow_d = overflow_q;
        push       = 1'b0;
`endif
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == '0) state_d = S_IDLE;
                else                  init_cnt_d = init_cnt_q - IW'(1);
            end
            S_IDLE: begin
                if (usr_valid_i && usr_ready_q) begin
                    if (usr_flag_i && !usr_open_i) begin
                        cov_flag_d = 1'b1;
                        cov_x_d    = usr_x_i;
                        cov_y_d    = usr_y_i;
                    end else if (usr_open_i && !usr_flag_i) begin
                        cur_x_d    = usr_x_i;
                        cur_y_d    = usr_y_i;
                        cov_x_d    = usr_x_i;
                        cov_y_d    = usr_y_i;
                        cov_open_d = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
`ifdef FLOOD_FILL_EN
                state_d = S_POP;
`else
                state_d = S_IDLE;
`endif
                if (cov_opened_i) begin
                    cells_d = cells_q + CW'(1);
                    if (is_mine_i) begin
                        mine_hit_d = 1'b1;
                        state_d    = S_IDLE;
`ifdef FLOOD_FILL_EN
                        sp_d       = '0;
                    end else if (adj_count_i == 4'd0) begin
                        nbr_d   = '0;
                        state_d = S_EXPAND;
`endif
                    end
                end
            end
`ifdef FLOOD_FILL_EN
            S_EXPAND: begin
                if (nbr_valid) begin
                    if (sp_q == SP_FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_ONE;
                    end
                end
                if (nbr_q == 3'd7) state_d = S_POP;
                else               nbr_d   = nbr_q + 3'd1;
            end
            S_POP: begin
                if (sp_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    sp_d       = sp_q - SP_ONE;
                    cur_x_d    = top_data[IW-1:Y_COORD_BITS];
                    cur_y_d    = top_data[Y_COORD_BITS-1:0];
                    cov_x_d    = top_data[IW-1:Y_COORD_BITS];
                    cov_y_d    = top_data[Y_COORD_BITS-1:0];
                    cov_open_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        usr_ready_d = (state_d == S_IDLE) && !mine_hit_d;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_INIT;
            init_cnt_q  <= INIT_LAST;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cov_x_q     <= '0;
            cov_y_q     <= '0;
            cov_flag_q  <= 1'b0;
            cov_open_q  <= 1'b0;
            usr_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            mine_hit_q  <= 1'b0;
            cells_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cov_x_q     <= cov_x_d;
            cov_y_q     <= cov_y_d;
            cov_flag_q  <= cov_flag_d;
            cov_open_q  <= cov_open_d;
            usr_ready_q <= usr_ready_d;
            busy_q      <= busy_d;
            mine_hit_q  <= mine_hit_d;
            cells_q     <= cells_d;
        end
    end

    assign usr_ready_o    = usr_ready_q;
    assign cov_flag_o     = cov_flag_q;
    assign cov_open_o     = cov_open_q;
    assign cov_x_o        = cov_x_q;
    assign cov_y_o        = cov_y_q;
    assign busy_o         = busy_q;
    assign mine_hit_o     = mine_hit_q;
    assign cells_opened_o = cells_q;

endmodule

// File: tb/tb_flood_fill_ctrl.sv
// Directed bench for flood_fill_ctrl with a behavioural cover-array model.
// Expectations follow the build option FLOOD_FILL_EN; with it defined two
// extra instances cover the small-board flood and the LIFO overflow cases.

module tb_flood_fill_ctrl;

`ifdef FLOOD_FILL_EN
    localparam int LAT_NZ = 4, LAT_ZERO = 36, ZERO_OPENS = 9, ZERO_CELLS = 8;
`else
    localparam int LAT_NZ = 3, LAT_ZERO = 3, ZERO_OPENS = 1, ZERO_CELLS = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       usr_valid, usr_ready, usr_flag, usr_open;
    logic [3:0] usr_x, usr_y;
    logic       cov_flag, cov_open, cov_opened, is_mine, busy, mine_hit, overflow;
    logic [3:0] cov_x, cov_y, adj_count;
    logic [8:0] cells_opened;

    int vectors = 0;
    int miscompares = 0;

    logic       op_m [256];
    logic       fl_m [256];
    logic       zero_en, mine_en;
    logic [3:0] zero_x, zero_y, mine_x, mine_y, adj_nz;
    int         open_pulses = 0;
    int         flag_pulses = 0;

    flood_fill_ctrl u_dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .usr_valid_i(usr_valid), .usr_ready_o(usr_ready),
        .usr_flag_i(usr_flag), .usr_open_i(usr_open),
        .usr_x_i(usr_x), .usr_y_i(usr_y),
        .cov_flag_o(cov_flag), .cov_open_o(cov_open),
        .cov_x_o(cov_x), .cov_y_o(cov_y),
        .cov_opened_i(cov_opened), .adj_count_i(adj_count), .is_mine_i(is_mine),
        .busy_o(busy), .mine_hit_o(mine_hit), .overflow_o(overflow),
        .cells_opened_o(cells_opened)
    );

    assign adj_count = (zero_en && cov_x == zero_x && cov_y == zero_y) ? 4'd0 : adj_nz;
    assign is_mine   = mine_en && cov_x == mine_x && cov_y == mine_y;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cov_opened <= 1'b0;
            for (int i = 0; i < 256; i++) begin
                op_m[i] <= 1'b0;
                fl_m[i] <= 1'b0;
            end
        end else begin
            cov_opened <= 1'b0;
            if (cov_open && !op_m[{cov_y, cov_x}] && !fl_m[{cov_y, cov_x}]) begin
                op_m[{cov_y, cov_x}] <= 1'b1;
                cov_opened <= 1'b1;
            end
            if (cov_flag) fl_m[{cov_y, cov_x}] <= !fl_m[{cov_y, cov_x}];
        end
    end

    always @(posedge clk) begin
        if (cov_open) open_pulses++;
        if (cov_flag) flag_pulses++;
    end

`ifdef FLOOD_FILL_EN
    // 4x4 board, 128-entry LIFO, every cell zero-count
    logic       valid1, ready1, cflag1, copen1, copened1, busy1, mh1, ov1;
    logic [1:0] x1, y1, cx1, cy1;
    logic [4:0] cells1;
    logic       op1 [16];
    flood_fill_ctrl #(.X_SIZE(4), .Y_SIZE(4), .X_COORD_BITS(2), .Y_COORD_BITS(2),
                      .STACK_DEPTH(128), .STACK_BITS(7)) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n),
        .usr_valid_i(valid1), .usr_ready_o(ready1),
        .usr_flag_i(1'b0), .usr_open_i(1'b1), .usr_x_i(x1), .usr_y_i(y1),
        .cov_flag_o(cflag1), .cov_open_o(copen1), .cov_x_o(cx1), .cov_y_o(cy1),
        .cov_opened_i(copened1), .adj_count_i(4'd0), .is_mine_i(1'b0),
        .busy_o(busy1), .mine_hit_o(mh1), .overflow_o(ov1), .cells_opened_o(cells1)
    );
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copened1 <= 1'b0;
            for (int i = 0; i < 16; i++) op1[i] <= 1'b0;
        end else begin
            copened1 <= 1'b0;
            if (copen1 && !op1[{cy1, cx1}]) begin
                op1[{cy1, cx1}] <= 1'b1;
                copened1 <= 1'b1;
            end
        end
    end

    // 16x16 board, 4-entry LIFO, only (5,5) is zero-count
    logic       valid2, ready2, cflag2, copen2, copened2, busy2, mh2, ov2;
    logic [3:0] cx2, cy2, adj2;
    logic [8:0] cells2;
    logic       op2 [256];
    int         open_pulses2 = 0;
    flood_fill_ctrl #(.STACK_DEPTH(4), .STACK_BITS(2)) u_dut2 (
        .clk_i(clk), .reset_n_i(rst_n),
        .usr_valid_i(valid2), .usr_ready_o(ready2),
        .usr_flag_i(1'b0), .usr_open_i(1'b1), .usr_x_i(4'd5), .usr_y_i(4'd5),
        .cov_flag_o(cflag2), .cov_open_o(copen2), .cov_x_o(cx2), .cov_y_o(cy2),
        .cov_opened_i(copened2), .adj_count_i(adj2), .is_mine_i(1'b0),
        .busy_o(busy2), .mine_hit_o(mh2), .overflow_o(ov2), .cells_opened_o(cells2)
    );
    assign adj2 = (cx2 == 4'd5 && cy2 == 4'd5) ? 4'd0 : 4'd1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copened2 <= 1'b0;
            for (int i = 0; i < 256; i++) op2[i] <= 1'b0;
        end else begin
            copened2 <= 1'b0;
            if (copen2 && !op2[{cy2, cx2}]) begin
                op2[{cy2, cx2}] <= 1'b1;
                copened2 <= 1'b1;
            end
        end
    end
    always @(posedge clk) if (copen2) open_pulses2++;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, k, ob, fb, hi;
        rst_n = 1'b0;
        usr_valid = 1'b0; usr_flag = 1'b0; usr_open = 1'b0; usr_x = '0; usr_y = '0;
        zero_en = 1'b0; mine_en = 1'b0; zero_x = '0; zero_y = '0;
        mine_x = '0; mine_y = '0; adj_nz = 4'd3;
`ifdef FLOOD_FILL_EN
        valid1 = 1'b0; x1 = '0; y1 = '0; valid2 = 1'b0;
`endif
        #23;
        check("rst_ready", usr_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_cov_strobes", {cov_flag, cov_open}, 0);
        check("rst_cov_xy", {cov_x, cov_y}, 0);
        check("rst_mine_hit", mine_hit, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cells", cells_opened, 0);

        // INIT length
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (usr_ready !== 1'b1 && n < 400) begin step(); n++; end
        check("init_cycles", n, 256);
        check("init_busy_low", busy, 0);

        // flag toggle at (3,5)
        ob = open_pulses; fb = flag_pulses;
        usr_valid = 1'b1; usr_flag = 1'b1; usr_x = 4'd3; usr_y = 4'd5;
        step();
        usr_valid = 1'b0; usr_flag = 1'b0;
        check("flag_pulse", cov_flag, 1);
        check("flag_xy", {cov_x, cov_y}, {4'd3, 4'd5});
        check("flag_ready", usr_ready, 1);
        step();
        check("flag_one_cycle", cov_flag, 0);

        // both kinds set: discarded
        usr_valid = 1'b1; usr_flag = 1'b1; usr_open = 1'b1; usr_x = 4'd6; usr_y = 4'd6;
        step();
        usr_valid = 1'b0; usr_flag = 1'b0; usr_open = 1'b0;
        step();
        check("both_ready", usr_ready, 1);
        check("flag_pulse_count", flag_pulses - fb, 1);
        check("flag_no_open", open_pulses - ob, 0);

        // open (2,2), non-zero, not a mine
        ob = open_pulses;
        usr_valid = 1'b1; usr_open = 1'b1; usr_x = 4'd2; usr_y = 4'd2;
        step();
        usr_valid = 1'b0; usr_open = 1'b0;
        k = 1;
        check("nz_open_pulse", cov_open, 1);
        check("nz_xy", {cov_x, cov_y}, {4'd2, 4'd2});
        check("nz_ready_low", usr_ready, 0);
        while (usr_ready !== 1'b1 && k < 50) begin
            step(); k++;
            if (k == 2) check("nz_wait_xy_held", {cov_open, cov_x, cov_y}, {1'b0, 4'd2, 4'd2});
        end
        check("nz_latency", k, LAT_NZ);
        check("nz_cells", cells_opened, 1);
        check("nz_open_count", open_pulses - ob, 1);

        // zero-count cell at (4,6); neighbour (3,5) is flagged
        ob = open_pulses;
        zero_en = 1'b1; zero_x = 4'd4; zero_y = 4'd6;
        usr_valid = 1'b1; usr_open = 1'b1; usr_x = 4'd4; usr_y = 4'd6;
        step();
        usr_valid = 1'b0; usr_open = 1'b0;
        k = 1;
        while (usr_ready !== 1'b1 && k < 300) begin step(); k++; end
        check("zero_latency", k, LAT_ZERO);
        check("zero_open_count", open_pulses - ob, ZERO_OPENS);
        check("zero_cells", cells_opened, 1 + ZERO_CELLS);
        check("zero_overflow", overflow, 0);
        check("zero_flag_kept_closed", op_m[{4'd5, 4'd3}], 0);

        // mine at (7,7)
        ob = open_pulses;
        zero_en = 1'b0; mine_en = 1'b1; mine_x = 4'd7; mine_y = 4'd7;
        usr_valid = 1'b1; usr_open = 1'b1; usr_x = 4'd7; usr_y = 4'd7;
        step();
        usr_x = 4'd8;
        k = 1;
        while (mine_hit !== 1'b1 && k < 20) begin step(); k++; end
        check("mine_hit_set", mine_hit, 1);
        check("mine_cells", cells_opened, 2 + ZERO_CELLS);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (usr_ready !== 1'b0) hi++;
        end
        check("mine_ready_held_low", hi, 0);
        check("mine_no_more_opens", open_pulses - ob, 1);
        check("mine_busy_low", busy, 0);

        // reset in the middle of operation
        #3 rst_n = 1'b0;
        usr_valid = 1'b0; usr_open = 1'b0; mine_en = 1'b0;
        #1;
        check("mid_rst_mine_hit", mine_hit, 0);
        check("mid_rst_cells", cells_opened, 0);
        check("mid_rst_ready_busy", {usr_ready, busy}, {1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (usr_ready !== 1'b1 && n < 400) begin step(); n++; end
        check("reinit_cycles", n, 256);

`ifdef FLOOD_FILL_EN
        // full flood of a 4x4 all-zero board from a corner
        valid1 = 1'b1; x1 = 2'd0; y1 = 2'd0;
        step();
        valid1 = 1'b0;
        k = 1;
        while (ready1 !== 1'b1 && k < 2000) begin step(); k++; end
        check("b4_ready_back", ready1, 1);
        check("b4_cells", cells1, 16);
        check("b4_overflow", ov1, 0);
        check("b4_busy", busy1, 0);

        // LIFO overflow: 8 neighbours, only 4 fit
        ob = open_pulses2;
        valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        k = 1;
        while (ready2 !== 1'b1 && k < 500) begin step(); k++; end
        check("ovf_flag", ov2, 1);
        check("ovf_cells", cells2, 5);
        check("ovf_open_count", open_pulses2 - ob, 5);
        check("ovf_last_opened", {cx2, cy2}, {4'd4, 4'd4});
        check("ovf_far_nbr_closed", op2[{4'd6, 4'd6}], 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flood_fill_ctrl.md
# flood_fill_ctrl

- Sequences open and flag commands into the board cover array on behalf of the player input path.
- Opening a cell with zero adjacent mines automatically opens its in-bounds neighbours (flood fill) through an internal LIFO.
- Sits between the input/cursor logic and the board cover memory, and is the only driver of the cover's flag/open/coordinate inputs.
- Also tracks mine hits and the opened-cell count.

## Interface
- x_size, 16, board width in cells
- y_size, 16, board height in cells
- x_coord_bits, 4, width of x coordinate
- y_coord_bits, 4, width of y coordinate
- stack_depth, 256, LIFO entries (each {x,y})
- stack_bits, 8, log2(stack_depth)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset (already decided)
- usr_valid  in  1  player command valid
- usr_ready  out  1  controller can accept a command
- usr_flag  in  1  command is flag toggle
- usr_open  in  1  command is open
- usr_x  in  x_coord_bits  command x
- usr_y  in  y_coord_bits  command y
- cov_flag  out  1  flag strobe to cover array
- cov_open  out  1  open strobe to cover array
- cov_x  out  x_coord_bits  cover array x address
- cov_y  out  y_coord_bits  cover array y address
- cov_opened  in  1  cover array "cell transitioned to opened", registered, valid one cycle after cov_open
- adj_count  in  4  adjacent-mine count of cell at cov_x/cov_y, combinational
- is_mine  in  1  cell at cov_x/cov_y is a mine, combinational
- busy  out  1  state != IDLE
- mine_hit  out  1  sticky: a mine was opened
- overflow  out  1  sticky: a push was dropped because the LIFO was full
- cells_opened  out  x_coord_bits+y_coord_bits+1  count of cells opened since reset

## Operation
- **States:** INIT, IDLE, ISSUE, WAIT, EXPAND, POP.
- **INIT:** entered on reset. Holds for x_size*y_size cycles while the cover array clears itself, then goes to IDLE.
- **IDLE:** usr_ready=1 unless mine_hit. On usr_valid&usr_ready:
  - flag&~open: cov_flag=1 for exactly the next cycle at (usr_x,usr_y); stay IDLE.
  - open&~flag: latch cur=(usr_x,usr_y), go to ISSUE.
  - Both or neither set: command is consumed and discarded.
- **ISSUE:** cov_open=1, cov_x/y=cur for one cycle, then WAIT.
- **WAIT:** cov_x/y held at cur, cov_open=0.
  - cov_opened=1: cells_opened+1. Then:
    - is_mine: set mine_hit, clear LIFO, go to IDLE; usr_ready stays 0 until reset.
    - adj_count==0: go to EXPAND with nbr=0.
    - otherwise: go to POP.
  - cov_opened=0 (cell already open or flagged): go to POP.
- **EXPAND:** one neighbour per cycle, nbr 0..7 in order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
  - Out-of-range coordinates (below 0 or ≥ size, computed without wrap) are skipped.
  - In-range coordinates are pushed; a push while full is dropped and sets overflow.
  - After nbr 7, go to POP.
- **POP:** LIFO empty → IDLE; otherwise pop the top entry into cur → ISSUE.
- **Duplicates and flags:** duplicate pushes are harmless; the cover array ignores opens on opened or flagged cells, so flagged cells are never auto-opened.
- **LIFO:** push and pop never occur in the same cycle.

## Timing
- **Reset values:** state=INIT, usr_ready=0, busy=1, cov_*=0, mine_hit=0, overflow=0, cells_opened=0, LIFO empty.
- **reset_n mid-operation:** aborts immediately to the reset values.
- **First command:** usr_ready first rises x_size*y_size cycles after reset_n deasserts.
- **Flag command:** cov_flag pulses the cycle after acceptance; usr_ready stays 1.
- **Non-zero, non-mine open:** cov_open the cycle after acceptance; usr_ready returns 4 cycles after acceptance (ISSUE, WAIT, POP, IDLE).
- **Each popped cell:** 3 cycles (POP, ISSUE, WAIT).
- **Each zero cell:** +8 EXPAND cycles.
- **Outputs:** all registered; cov_x/cov_y are stable throughout ISSUE and WAIT.

## Configuration
- **FLOOD_FILL_EN defined:** behaviour as above.
- **FLOOD_FILL_EN undefined:**
  - LIFO and EXPAND are not built; overflow is tied to 0.
  - WAIT goes directly to IDLE after a non-mine result, so only the commanded cell is opened.

## Test plan
- Release reset_n with the 16x16 defaults → usr_ready rises exactly 256 cycles later; busy falls in the same cycle.
- Flag at (3,5) → one-cycle cov_flag with cov_x=3, cov_y=5; cov_open never asserted; usr_ready remains 1.
- Open (2,2) with adj_count=3, is_mine=0 → one cov_open pulse; cells_opened=1; usr_ready back 4 cycles after acceptance; LIFO empty.
- Open a mine at (7,7) → mine_hit=1, cells_opened=1; usr_ready held at 0 for 100 further cycles despite usr_valid; reset_n clears it.
- Set x_size=y_size=4, stack_depth=128, no mines, all adj_count=0; open (0,0) → cells_opened=16, overflow=0, return to IDLE.
- Set stack_depth=4; open interior zero cell (5,5) whose neighbours are non-zero → 4 pushes accepted, overflow=1, then exactly 4 neighbour opens.
